// File: rtl/fp_classify_pkg.sv
// fp_classify_pkg: shared class-bit indices, format enum and IEEE 754 field widths
package fp_classify_pkg;

    localparam int ClassNegInf       = 0;
    localparam int ClassNegNormal    = 1;
    localparam int ClassNegSubnormal = 2;
    localparam int ClassNegZero      = 3;
    localparam int ClassPosZero      = 4;
    localparam int ClassPosSubnormal = 5;
    localparam int ClassPosNormal    = 6;
    localparam int ClassPosInf       = 7;
    localparam int ClassSNan         = 8;
    localparam int ClassQNan         = 9;

    localparam logic [9:0] ClassCanonicalNan = 10'h200;

    localparam int SExpBits  = 8;
    localparam int SFracBits = 23;
    localparam int DExpBits  = 11;
    localparam int DFracBits = 52;

    typedef enum logic {
        FmtS = 1'b0,
        FmtD = 1'b1
    } fp_fmt_e;

endpackage

// File: rtl/fp_class_mask_encode.sv
// fp_class_mask_encode: combinational sign/exp/frac to one-hot FCLASS mask
module fp_class_mask_encode
    import fp_classify_pkg::*;
#(
    parameter int EXP_BITS  = 8,
    parameter int FRAC_BITS = 23
) (
    input  logic                 sign,
    input  logic [EXP_BITS-1:0]  exp,
    input  logic [FRAC_BITS-1:0] frac,
    output logic [9:0]           mask
);

    logic exp_zero, exp_ones, frac_zero, normal, nan;

    assign exp_zero  = exp == '0;
    assign exp_ones  = &exp;
    assign frac_zero = frac == '0;
    assign normal    = !exp_zero && !exp_ones;
    assign nan       = exp_ones && !frac_zero;

    assign mask[ClassNegInf]       = sign && exp_ones && frac_zero;
    assign mask[ClassNegNormal]    = sign && normal;
    assign mask[ClassNegSubnormal] = sign && exp_zero && !frac_zero;
    assign mask[ClassNegZero]      = sign && exp_zero && frac_zero;
    assign mask[ClassPosZero]      = !sign && exp_zero && frac_zero;
    assign mask[ClassPosSubnormal] = !sign && exp_zero && !frac_zero;
    assign mask[ClassPosNormal]    = !sign && normal;
    assign mask[ClassPosInf]       = !sign && exp_ones && frac_zero;
    // NaN quietness is the frac MSB; sign plays no part
    assign mask[ClassSNan]         = nan && !frac[FRAC_BITS-1];
    assign mask[ClassQNan]         = nan && frac[FRAC_BITS-1];

endmodule

// File: rtl/fp_classify_pipe.sv
// fp_classify_pipe: two-stage RISC-V FCLASS.S/D classifier with NaN-box check and valid/ready flow
module fp_classify_pipe
    import fp_classify_pkg::*;
#(
    parameter int FLEN     = 64,
    parameter int TAG_BITS = 5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_flush,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [FLEN-1:0]     i_operand,
    input  logic                i_fmt,
    input  logic [TAG_BITS-1:0] i_tag,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [9:0]          o_class,
    output logic [TAG_BITS-1:0] o_tag
);

    logic                s1_valid, s2_valid, s1_en, s2_en;
    logic [FLEN-1:0]     s1_operand;
    fp_fmt_e             s1_fmt;
    logic [TAG_BITS-1:0] s1_tag, s2_tag;
    logic [9:0]          s_mask, class_next, s2_class;

    assign s2_en   = !s2_valid || i_ready;
    assign s1_en   = !s1_valid || s2_en;
    assign o_ready = s1_en;
    assign o_valid = s2_valid;
    assign o_class = s2_class;
    assign o_tag   = s2_tag;

    fp_class_mask_encode #(.EXP_BITS(SExpBits), .FRAC_BITS(SFracBits)) u_enc_s (
        .sign (s1_operand[31]),
        .exp  (s1_operand[30:23]),
        .frac (s1_operand[22:0]),
        .mask (s_mask)
    );

    generate
        if (FLEN == 64) begin : g_d
            logic [9:0] d_mask;
            logic       boxed;
            fp_class_mask_encode #(.EXP_BITS(DExpBits), .FRAC_BITS(DFracBits)) u_enc_d (
                .sign (s1_operand[63]),
                .exp  (s1_operand[62:52]),
                .frac (s1_operand[51:0]),
                .mask (d_mask)
            );
            // a single held in a 64-bit register is only legal when NaN-boxed
            assign boxed      = &s1_operand[63:32];
            assign class_next = (s1_fmt == FmtD) ? d_mask : boxed ? s_mask : ClassCanonicalNan;
        end else begin : g_s
            assign class_next = s_mask;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid   <= 1'b0;
            s1_operand <= '0;
            s1_fmt     <= FmtS;
            s1_tag     <= '0;
            s2_valid   <= 1'b0;
            s2_class   <= '0;
            s2_tag     <= '0;
        end else begin
            if (i_flush)
                s1_valid <= 1'b0;
            else if (s1_en)
                s1_valid <= i_valid;
            if (s1_en) begin
                s1_operand <= i_operand;
                s1_fmt     <= fp_fmt_e'(i_fmt);
                s1_tag     <= i_tag;
            end
            if (i_flush)
                s2_valid <= 1'b0;
            else if (s2_en)
                s2_valid <= s1_valid;
            if (s2_en) begin
                s2_class <= class_next;
                s2_tag   <= s1_tag;
            end
        end
    end

endmodule
